ospi_flash_ctrl: RTL and testbench

OSPI_FLASH_CTRL -- requirements
Module: ospi_flash_ctrl

---
 rtl/ospi_flash_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ospi_flash_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ospi_flash_ctrl.sv
// Octal/quad/dual/single SPI NOR flash controller.
// Runs one read, page-program or sector-erase transaction per start strobe.
// Each bus beat is two clk cycles: A (OSPI_CLK low, new io_out) and B (OSPI_CLK high).
// io_in is captured at the clk edge that ends cycle A, which is the rising edge of OSPI_CLK.
//
// Handshake: start is a one-cycle request strobe. It is accepted only in IDLE, and
// op/address/data_in are captured with it. done is a one-cycle completion pulse, and
// err qualifies done. busy is high from the cycle after start up to, but not
// including, the done cycle.
module ospi_flash_ctrl #(
    parameter int ADDR_WIDTH   = 24,
    parameter int DATA_WIDTH   = 32,
    parameter int LANES        = 8,
    parameter int DUMMY_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  HOLD_N,
    output logic                  OSPI_CLK,
    output logic                  OSPI_CS,
    output logic [LANES-1:0]      io_out,
    output logic                  io_oe,
    input  logic [LANES-1:0]      io_in,
    output logic [2:0]            state_dbg
);

    localparam int SR_W0      = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int SR_W       = (SR_W0 > 8) ? SR_W0 : 8;
    localparam int CNT_W      = 16;
    localparam int CMD_BEATS  = 8 / LANES;
    localparam int ADDR_BEATS = ADDR_WIDTH / LANES;
    localparam int DATA_BEATS = DATA_WIDTH / LANES;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_PROG  = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_WREN, S_GAP, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE
    } state_t;

    state_t                  state, state_n;
    logic [1:0]              op_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH-1:0]   rx;
    logic [SR_W-1:0]         sr;
    logic [CNT_W-1:0]        cnt;
    logic                    half;
    logic                    err_q;

    logic                    in_beat;
    logic                    advance;
    logic                    beat_end;
    logic                    phase_end;
    logic [CNT_W-1:0]        beat_len;
    logic [1:0]              op_sel;
    logic [7:0]              cmd_byte;
    logic                    read_rx;
    logic                    drive_phase;

    // Beat bookkeeping and next-state selection; HOLD_N only freezes beat-carrying states.
    always_comb begin
        in_beat   = (state inside {S_WREN, S_CMD, S_ADDR, S_DUMMY, S_DATA});
        advance   = in_beat && HOLD_N;
        beat_end  = advance && half;
        beat_len  = CNT_W'(1);
        case (state)
            S_WREN, S_CMD: beat_len = CNT_W'(CMD_BEATS);
            S_ADDR:        beat_len = CNT_W'(ADDR_BEATS);
            S_DUMMY:       beat_len = CNT_W'(DUMMY_CYCLES);
            S_DATA:        beat_len = CNT_W'(DATA_BEATS);
            default:       beat_len = CNT_W'(1);
        endcase
        phase_end = beat_end && (cnt == beat_len - CNT_W'(1));

        // From IDLE the op has not been registered yet, so look at the live input.
        op_sel   = (state == S_IDLE) ? op : op_q;
        cmd_byte = 8'h00;
        case (op_sel)
            OP_READ:  cmd_byte = 8'h0B;
            OP_PROG:  cmd_byte = 8'h02;
            OP_ERASE: cmd_byte = 8'h20;
            default:  cmd_byte = 8'h00;
        endcase

        state_n = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_READ)     state_n = S_CMD;
                    else if (op == OP_ILL) state_n = S_DONE;
                    else                   state_n = S_WREN;
                end
            end
            S_WREN:  if (phase_end) state_n = S_GAP;
            S_GAP:   if (cnt == CNT_W'(1)) state_n = S_CMD;
            S_CMD:   if (phase_end) state_n = S_ADDR;
            S_ADDR: begin
                if (phase_end) begin
                    if (op_q == OP_ERASE)      state_n = S_DONE;
                    else if (op_q == OP_PROG)  state_n = S_DATA;
                    else if (DUMMY_CYCLES == 0) state_n = S_DATA;
                    else                       state_n = S_DUMMY;
                end
            end
            S_DUMMY: if (phase_end) state_n = S_DATA;
            S_DATA:  if (phase_end) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State register plus beat counters, request capture, transmit shifter and receive shifter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            op_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rx       <= '0;
            sr       <= '0;
            cnt      <= '0;
            half     <= 1'b0;
            err_q    <= 1'b0;
            data_out <= '0;
        end else begin
            state <= state_n;

            if (state == S_IDLE && start) begin
                op_q   <= op;
                addr_q <= address;
                data_q <= data_in;
                err_q  <= (op == OP_ILL);
            end

            if (state_n != state) begin
                cnt  <= '0;
                half <= 1'b0;
            end else if (state == S_GAP) begin
                cnt <= cnt + CNT_W'(1);
            end else if (advance) begin
                half <= ~half;
                if (half) cnt <= cnt + CNT_W'(1);
            end

            // Each phase loads its field left-aligned so the MSB group is always at the top.
            if (state_n != state) begin
                case (state_n)
                    S_WREN:  sr <= SR_W'(8'h06) << (SR_W - 8);
                    S_CMD:   sr <= SR_W'(cmd_byte) << (SR_W - 8);
                    S_ADDR:  sr <= SR_W'(addr_q) << (SR_W - ADDR_WIDTH);
                    S_DATA:  sr <= SR_W'(data_q) << (SR_W - DATA_WIDTH);
                    default: sr <= '0;
                endcase
            end else if (beat_end) begin
                sr <= sr << LANES;
            end

            if (read_rx && advance && !half)
                rx <= (rx << LANES) | DATA_WIDTH'(io_in);

            if (read_rx && phase_end)
                data_out <= rx;
        end
    end

    // Pad-side and status outputs decoded from the current state and beat half.
    always_comb begin
        read_rx     = (state == S_DATA) && (op_q == OP_READ);
        drive_phase = (state inside {S_WREN, S_CMD, S_ADDR}) ||
                      ((state == S_DATA) && (op_q == OP_PROG));
        OSPI_CS     = ~in_beat;
        OSPI_CLK    = in_beat && half && HOLD_N;
        io_oe       = in_beat && !((op_q == OP_READ) && (state inside {S_DUMMY, S_DATA}));
        io_out      = drive_phase ? sr[SR_W-1 -: LANES] : '0;
        busy        = (state != S_IDLE) && (state != S_DONE);
        done        = (state == S_DONE);
        err         = (state == S_DONE) && err_q;
        state_dbg   = state;
    end

endmodule

// File: tb/tb_ospi_flash_ctrl.sv
// Bench for ospi_flash_ctrl: expected bus cycles are generated from the transaction
// description (command, address, dummy and data fields expanded into two-cycle beats),
// then stretched by HOLD_N and compared against the DUT every cycle.
module tb_ospi_flash_ctrl;

    localparam int AW     = 24;
    localparam int DW     = 32;
    localparam int L      = 8;
    localparam int DC     = 8;
    localparam int DSTART = 8 / L + AW / L + DC;
    localparam int DBEATS = DW / L;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = '0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          busy, done, err;
    logic          hold_n = 1'b1;
    logic          ospi_clk, ospi_cs, io_oe;
    logic [L-1:0]  io_out;
    logic [L-1:0]  io_in = '0;
    logic [2:0]    state_dbg;

    logic          start1 = 1'b0;
    logic [1:0]    op1 = '0;
    logic [AW-1:0] address1 = '0;
    logic [DW-1:0] data_in1 = '0;
    logic [DW-1:0] data_out1;
    logic          busy1, done1, err1, clk1, cs1, oe1;
    logic [0:0]    io_out1;
    logic [0:0]    io_in1 = '0;
    logic          hold1 = 1'b1;
    logic [2:0]    state_dbg1;

    int checks = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    // clock / reset
    always #5 clk = ~clk;

    ospi_flash_ctrl u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .address(address),
        .data_in(data_in), .data_out(data_out), .busy(busy), .done(done), .err(err),
        .HOLD_N(hold_n), .OSPI_CLK(ospi_clk), .OSPI_CS(ospi_cs), .io_out(io_out),
        .io_oe(io_oe), .io_in(io_in), .state_dbg(state_dbg)
    );

    ospi_flash_ctrl #(.LANES(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .op(op1), .address(address1),
        .data_in(data_in1), .data_out(data_out1), .busy(busy1), .done(done1), .err(err1),
        .HOLD_N(hold1), .OSPI_CLK(clk1), .OSPI_CS(cs1), .io_out(io_out1),
        .io_oe(oe1), .io_in(io_in1), .state_dbg(state_dbg1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic beat, busy, cs, ck, oe, io_chk, done, err, upd;
        logic [L-1:0]  io;
        logic [DW-1:0] dout;
    } cyc_t;

    cyc_t          nom_q[$];
    logic [DW-1:0] exp_dout = '0;
    logic [DW-1:0] flash_word = '0;

    function automatic cyc_t mk_idle();
        cyc_t e;
        e.beat = 0; e.busy = 0; e.cs = 1; e.ck = 0; e.oe = 0; e.io_chk = 1;
        e.done = 0; e.err = 0; e.upd = 0; e.io = '0; e.dout = '0;
        return e;
    endfunction

    function automatic void push_cyc(input logic beat, input logic cs, input logic ck,
                                     input logic oe, input logic io_chk, input logic [L-1:0] io);
        cyc_t e;
        e = mk_idle();
        e.beat = beat; e.busy = 1; e.cs = cs; e.ck = ck; e.oe = oe; e.io_chk = io_chk; e.io = io;
        nom_q.push_back(e);
    endfunction

    function automatic void push_field(input logic [31:0] val, input int nbits);
        for (int g = 0; g < nbits / L; g++) begin
            logic [L-1:0] grp;
            grp = L'(val >> (nbits - L * (g + 1)));
            push_cyc(1, 0, 0, 1, 1, grp);
            push_cyc(1, 0, 1, 1, 1, grp);
        end
    endfunction

    function automatic void push_quiet(input int beats);
        for (int b = 0; b < beats; b++) begin
            push_cyc(1, 0, 0, 0, 0, '0);
            push_cyc(1, 0, 1, 0, 0, '0);
        end
    endfunction

    function automatic void push_gap();
        push_cyc(0, 1, 0, 0, 1, '0);
        push_cyc(0, 1, 0, 0, 1, '0);
    endfunction

    function automatic void push_done(input logic e_err, input logic upd, input logic [DW-1:0] dv);
        cyc_t e;
        e = mk_idle();
        e.done = 1; e.err = e_err; e.upd = upd; e.dout = dv;
        nom_q.push_back(e);
    endfunction

    function automatic void build_txn(input logic [1:0] t_op, input logic [AW-1:0] t_addr,
                                      input logic [DW-1:0] t_din, input logic [DW-1:0] t_word);
        nom_q.push_back(mk_idle());
        case (t_op)
            2'b00: begin
                push_field(32'h0B, 8); push_field(32'(t_addr), AW);
                push_quiet(DC); push_quiet(DBEATS); push_done(0, 1, t_word);
            end
            2'b01: begin
                push_field(32'h06, 8); push_gap(); push_field(32'h02, 8);
                push_field(32'(t_addr), AW); push_field(t_din, DW); push_done(0, 0, '0);
            end
            2'b10: begin
                push_field(32'h06, 8); push_gap(); push_field(32'h20, 8);
                push_field(32'(t_addr), AW); push_done(0, 0, '0);
            end
            default: push_done(1, 0, '0);
        endcase
    endfunction

    // scoreboard: one expected cycle per clk; HOLD_N repeats a beat cycle with the clock parked low
    always @(negedge clk) begin : cmp
        cyc_t e;
        if (chk_en) begin
            if (nom_q.size() > 0) begin
                e = nom_q[0];
                if (e.beat && !hold_n) e.ck = 1'b0;
                else e = nom_q.pop_front();
            end else begin
                e = mk_idle();
            end
            if (e.done && e.upd) exp_dout = e.dout;
            check("ctrl{busy,cs,clk,oe,done,err}",
                  64'({busy, ospi_cs, ospi_clk, io_oe, done, err}),
                  64'({e.busy, e.cs, e.ck, e.oe, e.done, e.err}));
            if (e.io_chk) check("io_out", 64'(io_out), 64'(e.io));
            check("data_out", 64'(data_out), 64'(exp_dout));
            if (reset) begin
                nom_q.delete();
                exp_dout = '0;
            end
        end
    end

    // flash model: returns flash_word on the data beats of a read
    int   fl_cnt = 0;
    logic fl_prev = 1'b0;
    always @(negedge clk) begin
        if (ospi_cs) fl_cnt = 0;
        else if (ospi_clk && !fl_prev) fl_cnt++;
        fl_prev = ospi_clk;
        if (!ospi_cs && fl_cnt >= DSTART && fl_cnt < DSTART + DBEATS)
            io_in = flash_word[DW-1-L*(fl_cnt-DSTART) -: L];
        else
            io_in = L'($urandom);
    end

    // bus recorder for the literal checks
    int         busy_cnt = 0, gap_cnt = 0, cs_cnt = 0, done_cnt = 0;
    logic [7:0] bus_q[$];
    logic       rec_prev = 1'b0;
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (busy && ospi_cs) gap_cnt++;
        if (!ospi_cs) cs_cnt++;
        if (done) done_cnt++;
        if (ospi_clk && !rec_prev && io_oe) bus_q.push_back(io_out);
        rec_prev = ospi_clk;
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rec();
        busy_cnt = 0; gap_cnt = 0; cs_cnt = 0; done_cnt = 0;
        bus_q.delete();
    endtask

    task automatic run_txn(input logic [1:0] t_op, input logic [AW-1:0] t_addr,
                           input logic [DW-1:0] t_din, input logic [DW-1:0] t_word,
                           input int hold_mode, input logic mid_start);
        int nom_len, mid_n, n;
        start = 1; op = t_op; address = t_addr; data_in = t_din; flash_word = t_word; hold_n = 1;
        clear_rec();
        build_txn(t_op, t_addr, t_din, t_word);
        nom_len = nom_q.size() - 2;
        mid_n = (mid_start && nom_len > 4) ? int'($urandom_range(1, nom_len - 3)) : -1;
        cyc();
        start = 0;
        n = 0;
        while (nom_q.size() > 0 && n < 400) begin
            case (hold_mode)
                1:       hold_n = ($urandom_range(0, 3) != 0);
                2:       hold_n = !(n >= 3 && n < 13);
                default: hold_n = 1;
            endcase
            if (n == mid_n) begin
                start = 1; op = 2'($urandom); address = AW'($urandom); data_in = $urandom;
            end else begin
                start = 0;
            end
            cyc();
            n++;
        end
        start = 0; hold_n = 1;
        check("txn_complete", 64'(nom_q.size()), 64'd0);
        nom_q.delete();
    endtask

    task automatic reset_mid();
        start = 1; op = 2'b00; address = AW'($urandom); flash_word = $urandom;
        build_txn(2'b00, address, '0, flash_word);
        cyc();
        start = 0;
        repeat (25) cyc();
        clear_rec();
        reset = 1;
        cyc();
        reset = 0;
        check("reset_cs_high", 64'(ospi_cs), 64'd1);
        check("reset_busy_low", 64'(busy), 64'd0);
        repeat (5) cyc();
        check("reset_no_done", 64'(done_cnt), 64'd0);
    endtask

    task automatic erase_serial();
        logic [39:0] bits;
        int nbits, bcnt, gcnt, dcnt;
        logic ecnt, prev;
        bits = '0; nbits = 0; bcnt = 0; gcnt = 0; dcnt = 0; ecnt = 1'b1; prev = 1'b0;
        start1 = 1; op1 = 2'b10; address1 = 24'hFF0000;
        cyc();
        start1 = 0;
        for (int i = 0; i < 200 && dcnt == 0; i++) begin
            @(negedge clk);
            if (busy1) bcnt++;
            if (busy1 && cs1) gcnt++;
            if (clk1 && !prev && oe1) begin
                bits = {bits[38:0], io_out1[0]};
                nbits++;
            end
            prev = clk1;
            if (done1) begin
                dcnt++;
                ecnt = err1;
            end
        end
        cyc();
        check("l1_bits", 64'(bits), 64'h06_20FF_0000);
        check("l1_nbits", 64'(nbits), 64'd40);
        check("l1_busy_cycles", 64'(bcnt), 64'd82);
        check("l1_gap_cycles", 64'(gcnt), 64'd2);
        check("l1_done", 64'(dcnt), 64'd1);
        check("l1_err", 64'(ecnt), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] rd_exp[4];
        logic [7:0] pg_exp[9];
        rd_exp = '{8'h0B, 8'h12, 8'h34, 8'h56};
        pg_exp = '{8'h06, 8'h02, 8'h00, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'h5A, 8'h5A};

        reset = 1;
        repeat (3) cyc();
        check("rst_ctrl", 64'({busy, ospi_cs, ospi_clk, io_oe, done, err}), 64'b010000);
        check("rst_io_out", 64'(io_out), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        chk_en = 1;
        cyc();
        reset = 0;
        cyc();

        // read, default parameters
        run_txn(2'b00, 24'h123456, '0, 32'hDEADBEEF, 0, 0);
        check("rd_nbytes", 64'(bus_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) check("rd_byte", 64'(bus_q[i]), 64'(rd_exp[i]));
        check("rd_busy_cycles", 64'(busy_cnt), 64'd32);
        check("rd_data_out", 64'(data_out), 64'hDEADBEEF);
        check("rd_done_count", 64'(done_cnt), 64'd1);

        // program
        run_txn(2'b01, 24'h000100, 32'hA5A5_5A5A, '0, 0, 0);
        check("pg_nbytes", 64'(bus_q.size()), 64'd9);
        for (int i = 0; i < 9; i++) check("pg_byte", 64'(bus_q[i]), 64'(pg_exp[i]));
        check("pg_gap_cycles", 64'(gap_cnt), 64'd2);
        check("pg_busy_cycles", 64'(busy_cnt), 64'd20);
        check("pg_data_out_held", 64'(data_out), 64'hDEADBEEF);

        // read with a 10-cycle hold inside the address phase
        run_txn(2'b00, 24'h123456, '0, 32'hCAFEF00D, 2, 0);
        check("hold_busy_cycles", 64'(busy_cnt), 64'd42);
        check("hold_nbytes", 64'(bus_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) check("hold_byte", 64'(bus_q[i]), 64'(rd_exp[i]));
        check("hold_data_out", 64'(data_out), 64'hCAFEF00D);

        // illegal op
        run_txn(2'b11, 24'hABCDEF, '0, '0, 0, 0);
        check("ill_done_count", 64'(done_cnt), 64'd1);
        check("ill_busy_cycles", 64'(busy_cnt), 64'd0);
        check("ill_cs_low_cycles", 64'(cs_cnt), 64'd0);

        // erase with a second start while busy
        run_txn(2'b10, 24'h3C0000, '0, '0, 0, 1);
        check("er_busy_cycles", 64'(busy_cnt), 64'd12);
        check("er_done_count", 64'(done_cnt), 64'd1);

        // reset during the data phase of a read
        reset_mid();

        // randomized transactions
        for (int t = 0; t < 40; t++) begin
            run_txn(2'($urandom), AW'($urandom), $urandom, $urandom,
                    int'($urandom_range(0, 1)), 1'($urandom));
            check("rnd_done_count", 64'(done_cnt), 64'd1);
        end

        // single-lane erase
        erase_serial();

        repeat (3) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
